// File: rtl/balance_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : balance_arbiter
//  Description : Round-robin arbiter and sequencer for a single shared
//                account-balance register. Grants one ATM front-end at a
//                time, latches its deposit/withdrawal, updates the balance
//                (saturating deposits, rejected overdrafts) and returns a
//                one-cycle completion pulse with the requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module balance_arbiter #(
    parameter int               N_REQ        = 4,
    parameter int               BAL_W        = 64,
    parameter int               MONTO_W      = 32,
    parameter logic [BAL_W-1:0] INIT_BALANCE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         tipo_trans,
    input  logic [N_REQ*MONTO_W-1:0] monto_bus,
    output logic [N_REQ-1:0]         gnt,
    output logic                     done,
    output logic [2:0]               done_id,
    output logic                     balance_actualizado,
    output logic                     fondos_insuficientes,
    output logic [BAL_W-1:0]         balance
);

    localparam int         c_SUM_W = BAL_W + 1;
    localparam logic [2:0] c_LAST  = 3'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [2:0]           r_rr;      // highest-priority requester for next grant
    logic [2:0]           r_idx;     // requester currently being served
    logic                 r_tipo;    // latched type: 1 = withdrawal
    logic [MONTO_W-1:0]   r_amt;     // latched amount

    // Requests and types padded to 8 so a 3-bit index is always in range.
    logic [7:0]           w_req_pad;
    logic [7:0]           w_tipo_pad;
    logic [MONTO_W-1:0]   w_monto [8];

    assign w_req_pad  = 8'(req);
    assign w_tipo_pad = 8'(tipo_trans);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < N_REQ) begin : g_live
                assign w_monto[gi] = monto_bus[gi*MONTO_W +: MONTO_W];
            end else begin : g_pad
                assign w_monto[gi] = '0;
            end
        end
    endgenerate

    logic                 w_any;
    logic [2:0]           w_sel;
    logic [3:0]           w_cand;

    // Round-robin search: first set request starting at r_rr, wrapping mod N_REQ.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = r_rr;
        w_cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rr} + 4'(k);
            if (w_cand >= 4'(N_REQ)) begin
                w_cand = w_cand - 4'(N_REQ);
            end
            if (!w_any && w_req_pad[w_cand[2:0]]) begin
                w_any = 1'b1;
                w_sel = w_cand[2:0];
            end
        end
    end

    logic [BAL_W-1:0]     w_amt_ext;
    logic [c_SUM_W-1:0]   w_sum;
    logic [BAL_W-1:0]     w_dep;
    logic                 w_wd_ok;
    logic                 w_still;

    assign w_amt_ext = BAL_W'(r_amt);
    assign w_sum     = {1'b0, balance} + {1'b0, w_amt_ext};
    // A carry out of the balance width means overflow: clamp to all-ones.
    assign w_dep     = w_sum[BAL_W] ? '1 : w_sum[BAL_W-1:0];
    assign w_wd_ok   = (balance >= w_amt_ext);
    // The granted requester must keep its request up until completion.
    assign w_still   = w_req_pad[r_idx];

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state              <= S_IDLE;
            r_rr                 <= '0;
            r_idx                <= '0;
            r_tipo               <= 1'b0;
            r_amt                <= '0;
            gnt                  <= '0;
            done                 <= 1'b0;
            done_id              <= '0;
            balance_actualizado  <= 1'b0;
            fondos_insuficientes <= 1'b0;
            balance              <= INIT_BALANCE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done                 <= 1'b0;
                    balance_actualizado  <= 1'b0;
                    fondos_insuficientes <= 1'b0;
                    if (w_any) begin
                        gnt     <= N_REQ'(1) << w_sel;
                        r_idx   <= w_sel;
                        r_state <= S_LATCH;
                    end else begin
                        gnt     <= '0;
                    end
                end
                S_LATCH: begin
                    if (!w_still) begin
                        gnt     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tipo  <= w_tipo_pad[r_idx];
                        r_amt   <= w_monto[r_idx];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!w_still) begin
                        // Abandoned transaction: no write, no completion, pointer kept.
                        gnt     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        done    <= 1'b1;
                        done_id <= r_idx;
                        if (!r_tipo) begin
                            balance             <= w_dep;
                            balance_actualizado <= 1'b1;
                        end else if (w_wd_ok) begin
                            balance             <= balance - w_amt_ext;
                            balance_actualizado <= 1'b1;
                        end else begin
                            fondos_insuficientes <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done                 <= 1'b0;
                    balance_actualizado  <= 1'b0;
                    fondos_insuficientes <= 1'b0;
                    gnt                  <= '0;
                    r_rr                 <= (r_idx == c_LAST) ? 3'd0 : r_idx + 3'd1;
                    r_state              <= S_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_balance_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_balance_arbiter
//  Description : Directed self-checking bench for balance_arbiter: a table of
//                single transactions plus hand sequences for rotation, abort,
//                reset-mid-transaction and deposit saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_balance_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    // Main instance (INIT_BALANCE = 0)
    logic [3:0]   req, tipo;
    logic [31:0]  monto [4];
    logic [127:0] monto_bus;
    logic [3:0]   gnt;
    logic         done, upd, insuf;
    logic [2:0]   done_id;
    logic [63:0]  balance;

    // Saturation instance (INIT_BALANCE = 2^64-10)
    logic [3:0]   req_s, tipo_s;
    logic [31:0]  monto_s [4];
    logic [127:0] monto_bus_s;
    logic [3:0]   gnt_s;
    logic         done_s, upd_s, insuf_s;
    logic [2:0]   done_id_s;
    logic [63:0]  balance_s;

    int checks = 0;
    int errors = 0;

    assign monto_bus   = {monto[3], monto[2], monto[1], monto[0]};
    assign monto_bus_s = {monto_s[3], monto_s[2], monto_s[1], monto_s[0]};

    always #5 clk = ~clk;

    balance_arbiter #(
        .N_REQ(4), .BAL_W(64), .MONTO_W(32), .INIT_BALANCE(64'd0)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .tipo_trans(tipo), .monto_bus(monto_bus),
        .gnt(gnt), .done(done), .done_id(done_id), .balance_actualizado(upd),
        .fondos_insuficientes(insuf), .balance(balance)
    );

    balance_arbiter #(
        .N_REQ(4), .BAL_W(64), .MONTO_W(32), .INIT_BALANCE(64'hFFFF_FFFF_FFFF_FFF6)
    ) dut_sat (
        .clk(clk), .reset(reset), .req(req_s), .tipo_trans(tipo_s), .monto_bus(monto_bus_s),
        .gnt(gnt_s), .done(done_s), .done_id(done_id_s), .balance_actualizado(upd_s),
        .fondos_insuficientes(insuf_s), .balance(balance_s)
    );

    typedef struct {
        int          id;
        bit          wd;       // 1 = withdrawal
        logic [31:0] amt;
        logic [63:0] exp_bal;
        bit          exp_upd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for done on the selected instance; n = negedges waited.
    task automatic wait_done(input bit s, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s ? done_s : done) && n < 12);
        chk("done_seen", 64'(s ? done_s : done), 64'd1);
    endtask

    // One isolated transaction from an idle arbiter.
    task automatic run_txn(input bit s, input int id, input bit wd, input logic [31:0] amt,
                           input logic [63:0] exp_bal, input bit exp_upd);
        int n;
        @(negedge clk);
        if (s) begin req_s[id] = 1'b1; tipo_s[id] = wd; monto_s[id] = amt; end
        else   begin req[id]   = 1'b1; tipo[id]   = wd; monto[id]   = amt; end
        @(negedge clk);
        chk("gnt_after_req", 64'(s ? gnt_s : gnt), 64'(4'b0001 << id));
        wait_done(s, n);
        chk("done_latency", 64'(n), 64'd2);
        chk("done_id", 64'(s ? done_id_s : done_id), 64'(id));
        chk("upd_pulse", 64'(s ? upd_s : upd), 64'(exp_upd));
        chk("insuf_pulse", 64'(s ? insuf_s : insuf), 64'(!exp_upd));
        chk("balance", s ? balance_s : balance, exp_bal);
        chk("gnt_in_done", 64'(s ? gnt_s : gnt), 64'(4'b0001 << id));
        if (s) req_s[id] = 1'b0; else req[id] = 1'b0;
        @(negedge clk);
        chk("done_cleared", 64'(s ? done_s : done), 64'd0);
        chk("gnt_cleared", 64'(s ? gnt_s : gnt), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Structural invariants on every cycle out of reset.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (!$onehot0(gnt) || !$onehot0(gnt_s)
                || (done && (upd == insuf)) || (!done && (upd || insuf))
                || (done_s && (upd_s == insuf_s)) || (!done_s && (upd_s || insuf_s))) begin
                errors++;
                $display("FAIL invariant: gnt=%b gnt_s=%b done=%b upd=%b insuf=%b done_s=%b upd_s=%b insuf_s=%b",
                         gnt, gnt_s, done, upd, insuf, done_s, upd_s, insuf_s);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{0, 1'b0, 32'd500,  64'd500,  1'b1};
        vecs[1] = '{2, 1'b1, 32'd500,  64'd0,    1'b1};
        vecs[2] = '{2, 1'b1, 32'd1,    64'd0,    1'b0};
        vecs[3] = '{1, 1'b0, 32'd0,    64'd0,    1'b1};
        vecs[4] = '{3, 1'b1, 32'd0,    64'd0,    1'b1};
        vecs[5] = '{3, 1'b0, 32'd1234, 64'd1234, 1'b1};
        vecs[6] = '{1, 1'b1, 32'd1000, 64'd234,  1'b1};
        vecs[7] = '{0, 1'b1, 32'd235,  64'd234,  1'b0};

        reset = 1'b0;
        req = '0; tipo = '0; req_s = '0; tipo_s = '0;
        for (int i = 0; i < 4; i++) begin monto[i] = '0; monto_s[i] = '0; end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_done_id", 64'(done_id), 64'd0);
        chk("rst_upd", 64'(upd), 64'd0);
        chk("rst_insuf", 64'(insuf), 64'd0);
        chk("rst_balance", balance, 64'd0);
        chk("rst_balance_sat", balance_s, 64'hFFFF_FFFF_FFFF_FFF6);
        reset = 1'b1;

        // Table of isolated transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b0, vecs[i].id, vecs[i].wd, vecs[i].amt, vecs[i].exp_bal, vecs[i].exp_upd);
        end

        // Rotation with all four requesting deposits of 1
        do_reset();
        @(negedge clk);
        req = 4'b1111; tipo = 4'b0000;
        for (int i = 0; i < 4; i++) monto[i] = 32'd1;
        for (int j = 0; j < 5; j++) begin
            wait_done(1'b0, n);
            if (j > 0) chk("rr_spacing", 64'(n), 64'd4);
            else       chk("rr_first_latency", 64'(n), 64'd3);
            chk("rr_done_id", 64'(done_id), 64'(j % 4));
            chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (j % 4)));
            chk("rr_balance", balance, 64'(j + 1));
            chk("rr_upd", 64'(upd), 64'd1);
            if (j == 4) req = 4'b0000;
        end
        @(negedge clk);
        chk("rr_idle_gnt", 64'(gnt), 64'd0);

        // Drop req[1] during EXEC: abort, pointer stays at 1
        @(negedge clk);
        req[1] = 1'b1; tipo[1] = 1'b0; monto[1] = 32'd50;
        @(negedge clk);
        chk("abort_gnt_latch", 64'(gnt), 64'b0010);
        @(negedge clk);
        chk("abort_gnt_exec", 64'(gnt), 64'b0010);
        req[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        chk("abort_gnt", 64'(gnt), 64'd0);
        chk("abort_balance", balance, 64'd5);

        // Restart from pointer 1 with requesters 0,1,3 active
        monto[0] = 32'd10; monto[1] = 32'd20; monto[3] = 32'd30;
        tipo = 4'b0000;
        req = 4'b1011;
        wait_done(1'b0, n);
        chk("restart_id", 64'(done_id), 64'd1);
        chk("restart_balance", balance, 64'd25);
        req[1] = 1'b0;
        wait_done(1'b0, n);
        chk("rot_id_a", 64'(done_id), 64'd3);
        chk("rot_balance_a", balance, 64'd55);
        req[3] = 1'b0;
        wait_done(1'b0, n);
        chk("rot_id_b", 64'(done_id), 64'd0);
        chk("rot_balance_b", balance, 64'd65);
        req = 4'b0000;
        @(negedge clk);

        // Reset during EXEC of a deposit of 700
        @(negedge clk);
        req[0] = 1'b1; tipo[0] = 1'b0; monto[0] = 32'd700;
        @(negedge clk);
        chk("rstx_gnt", 64'(gnt), 64'b0001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstx_gnt_cleared", 64'(gnt), 64'd0);
        chk("rstx_done", 64'(done), 64'd0);
        chk("rstx_balance", balance, 64'd0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstx_no_done", 64'(done), 64'd0);
        end
        chk("rstx_balance_after", balance, 64'd0);

        // Saturation on the near-full instance
        run_txn(1'b1, 1, 1'b0, 32'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_txn(1'b1, 2, 1'b0, 32'd5,   64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_txn(1'b1, 3, 1'b1, 32'd1,   64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
